apb_regfile_ctrl: RTL

// APB slave controller that sequences every access to register_file and launches ECC operations.
// - Decodes APB transfers into register_file Rd_Wr_Id/offset/data_to_reg and returns register_file data_out on PRDATA.
// - Treats a write to CTRL as an operation command: pulses op_start, then holds busy until op_done or watchdog timeout.
// - Sits between the system APB bus and register_file / ECC core.
//

---
 rtl/ecc_ctrl_pkg.sv | 25 ++
 rtl/op_watchdog.sv | 36 +++
 rtl/apb_regfile_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/ecc_ctrl_pkg.sv
// Purpose : shared types and register offsets for the APB register-file controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: rf_acc_t (register_file Rd_Wr_Id), OFF_* word offsets, op_state_t (op FSM).
package ecc_ctrl_pkg;

  // Encoding matches the register_file Rd_Wr_Id input.
  typedef enum logic [1:0] {
    RF_READ  = 2'd0,
    RF_WRITE = 2'd1,
    RF_IDLE  = 2'd2
  } rf_acc_t;

  localparam logic [3:0] OFF_CTRL     = 4'd0;
  localparam logic [3:0] OFF_DATA_IN  = 4'd1;
  localparam logic [3:0] OFF_CW_WIDTH = 4'd2;
  localparam logic [3:0] OFF_NOISE    = 4'd3;

  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_LAUNCH = 2'd1,
    OP_BUSY   = 2'd2
  } op_state_t;

endpackage

// File: rtl/op_watchdog.sv
// Purpose : saturating cycle counter that flags an ECC operation running too long.
// Latency : o_expired is combinational on the current count (counts from 0 on the first enabled cycle).
// Backpressure: none; i_clear has priority over i_enable.
// Ports   : clk, rst (async active-low), i_clear, i_enable, o_expired.
module op_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WD_ON = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = WD_ON ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] r_cnt;

  // Saturates at TIMEOUT_CYC so a stalled enable can never wrap back into range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign o_expired = WD_ON && i_enable && (r_cnt == CNT_LAST);

endmodule

// File: rtl/apb_regfile_ctrl.sv
// Purpose : APB slave front-end for register_file; a CTRL write launches an ECC operation.
// Latency : zero-wait APB (PREADY in the ACCESS cycle); op_start pulses the cycle after the CTRL write.
// Backpressure: never stalls; writes while busy and bad addresses complete with PSLVERR.
// Ports   : clk/rst, APB slave (PSEL..PSLVERR), register_file side (rf_*), ECC side (op_*, busy, timeout_err).
module apb_regfile_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int AMBA_WORD   = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDR_W-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0] PWDATA,
  output logic [AMBA_WORD-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [1:0]           rf_rd_wr_id,
  output logic [3:0]           rf_offset,
  output logic [AMBA_WORD-1:0] rf_data_to_reg,
  input  logic [AMBA_WORD-1:0] rf_data_out,
  output logic                 op_start,
  output logic [1:0]           op_mode,
  input  logic                 op_done,
  output logic                 busy,
  output logic                 timeout_err
);

  op_state_t r_state;
  op_state_t w_next_state;
  logic [1:0] r_op_mode;
  logic       r_timeout_err;

  logic       w_access, w_addr_err, w_busy;
  logic       w_rd_ok, w_wr_ok, w_ctrl_wr, w_err;
  logic [3:0] w_offset;
  logic       w_wd_clear, w_wd_en, w_wd_expired;

  // Upper address bits are not decoded; the word offset aliases across them.
  logic w_unused_paddr;
  assign w_unused_paddr = ^PADDR[ADDR_W-1:6];

  // ---------------- APB decode (combinational) ----------------
  assign w_access   = PSEL & PENABLE;
  assign w_offset   = PADDR[5:2];
  assign w_addr_err = (PADDR[1:0] != 2'b00) || (w_offset > OFF_NOISE);
  assign w_busy     = (r_state != OP_IDLE);

  assign w_rd_ok   = w_access && !PWRITE && !w_addr_err;
  assign w_wr_ok   = w_access &&  PWRITE && !w_addr_err && !w_busy;
  assign w_ctrl_wr = w_wr_ok && (w_offset == OFF_CTRL);
  // Any write during an operation is rejected so parameters cannot change under the ECC core.
  assign w_err     = w_access && (w_addr_err || (PWRITE && w_busy));

  always_comb begin
    rf_rd_wr_id = RF_IDLE;
    if (w_rd_ok)      rf_rd_wr_id = RF_READ;
    else if (w_wr_ok) rf_rd_wr_id = RF_WRITE;
  end

  assign rf_offset      = w_access ? w_offset : 4'd0;
  assign rf_data_to_reg = PWDATA;
  assign PRDATA         = w_rd_ok ? rf_data_out : '0;
  assign PREADY         = w_access;
  assign PSLVERR        = w_err;

  // ---------------- Operation FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= OP_IDLE;
      r_op_mode     <= 2'b00;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_ctrl_wr) begin
        r_op_mode     <= PWDATA[1:0];
        r_timeout_err <= 1'b0;
      end else if ((r_state == OP_BUSY) && !op_done && w_wd_expired) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wd_clear   = 1'b1;
    w_wd_en      = 1'b0;
    case (r_state)
      OP_IDLE:   if (w_ctrl_wr) w_next_state = OP_LAUNCH;
      OP_LAUNCH: w_next_state = OP_BUSY;
      OP_BUSY: begin
        w_wd_clear = 1'b0;
        w_wd_en    = 1'b1;
        if (op_done || w_wd_expired) w_next_state = OP_IDLE;
      end
      default:   w_next_state = OP_IDLE;
    endcase
  end

  op_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_wd_expired)
  );

  assign op_start    = (r_state == OP_LAUNCH);
  assign busy        = w_busy;
  assign op_mode     = r_op_mode;
  assign timeout_err = r_timeout_err;

endmodule
